// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter sitting beside dmem on the rv32i data
// bus. Bytes written to TXDATA are queued in a small FIFO and serialized LSB
// first onto tx. STATUS exposes FIFO level, busy and a sticky overflow flag.
// Read data is registered so it lines up with dmem's synchronous read.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   addr[31:0]     data-bus byte address
//   din[31:0]      write data
//   we0/we1/we2    write enables; any one high means a write
//   dout[31:0]     registered STATUS read data, 0 for any other address
//   sel            registered: previous-cycle addr hit TXDATA or STATUS
//   tx             serial output, idle high, driven from a flop
//
// STATUS: bit0 full, bit1 empty, bit2 busy, bit3 ovf (write 1 to clear),
//         bits[12:4] FIFO count, all other bits 0.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 1085,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        we0,
  input  logic        we1,
  input  logic        we2,
  output logic [31:0] dout,
  output logic        sel,
  output logic        tx
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam int          BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Bus decode
  logic wr_en;
  logic txdata_hit;
  logic status_hit;

  assign wr_en      = we0 | we1 | we2;
  assign txdata_hit = (addr[31:2] == BASE_ADDR[31:2]);
  assign status_hit = (addr[31:2] == STATUS_ADDR[31:2]);

  // Byte lanes above the data byte and the low address bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], din[31:8]};

  // FIFO: pointers carry one extra wrap bit so full and empty are distinct.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] fifo_count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        ovf_reg;

  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  // A full FIFO drops the push even if the FSM pops in the same cycle.
  assign push       = wr_en & txdata_hit & ~full;

  // TX FSM state
  logic [1:0]    state_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          cnt_end;
  logic          busy;

  assign cnt_end = (baud_cnt_reg == BAUD_LAST);
  assign busy    = (state_reg != ST_IDLE);
  // Pops happen from IDLE, or at the end of STOP to chain frames with no gap.
  assign pop     = ~empty & ((state_reg == ST_IDLE) |
                             ((state_reg == ST_STOP) & cnt_end));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
      if (wr_en && txdata_hit && full) begin
        ovf_reg <= 1'b1;
      end else if (wr_en && status_hit && din[3]) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // tx is registered with the level of the state being entered, so the line
  // changes on the same edge as the state and never sees bus inputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (!empty) begin
            shift_reg    <= mem[rd_ptr_reg[AW-1:0]];
            baud_cnt_reg <= '0;
            state_reg    <= ST_START;
            tx_reg       <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt_end) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= 3'd0;
            state_reg    <= ST_DATA;
            tx_reg       <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_end) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {1'b0, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_end) begin
            baud_cnt_reg <= '0;
            if (!empty) begin
              shift_reg <= mem[rd_ptr_reg[AW-1:0]];
              state_reg <= ST_START;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
              tx_reg    <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  // Read side: snapshot of the state before this edge's updates.
  logic [31:0] status_word;
  logic [31:0] dout_reg;
  logic        sel_reg;

  assign status_word = {19'd0, 9'(fifo_count), ovf_reg, busy, empty, full};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg <= '0;
      sel_reg  <= 1'b0;
    end else begin
      dout_reg <= status_hit ? status_word : 32'd0;
      sel_reg  <= txdata_hit | status_hit;
    end
  end

  assign dout = dout_reg;
  assign sel  = sel_reg;
  assign tx   = tx_reg;

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

  localparam int          CPB    = 4;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam logic [31:0] STAT   = BASE + 32'd4;
  localparam int          FRAME  = 10 * CPB;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we0, we1, we2;
  logic [31:0] dout;
  logic        sel;
  logic        tx;

  int n_checks;
  int n_fail;
  int cyc;

  // Line receiver results
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         stop_err;
  logic [7:0] mon_byte;
  logic       mon_stop;
  logic       mon_abort;
  int         mon_start;

  logic [31:0] rd_data;
  logic        rd_sel;

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .din(din),
    .we0(we0),
    .we1(we1),
    .we2(we2),
    .dout(dout),
    .sel(sel),
    .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent 8N1 receiver: samples each bit at its middle on negedges.
  always begin
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      mon_start = cyc;
      mon_abort = 1'b0;
      for (int k = 0; k < 9 && !mon_abort; k++) begin
        for (int w = 0; w < ((k == 0) ? (CPB + CPB / 2) : CPB) && !mon_abort; w++) begin
          @(negedge clk);
          if (rst) mon_abort = 1'b1;
        end
        if (k < 8) mon_byte[k] = tx;
        else       mon_stop = tx;
      end
      if (!mon_abort) begin
        rx_q.push_back(mon_byte);
        start_q.push_back(mon_start);
        if (mon_stop !== 1'b1) stop_err++;
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    int w;
    @(negedge clk);
    addr = a;
    din  = d;
    w    = $urandom_range(0, 2);
    we0  = (w == 0);
    we1  = (w == 1);
    we2  = (w == 2);
    @(posedge clk);
    #1;
    we0  = 1'b0;
    we1  = 1'b0;
    we2  = 1'b0;
    addr = 32'h0;
    din  = $urandom;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(negedge clk);
    addr = a;
    @(posedge clk);
    #1;
    d    = dout;
    s    = sel;
    addr = 32'h0;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    addr = STAT;
    din  = 32'h0;
    we0  = 1'b0;
    we1  = 1'b0;
    we2  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    n_checks++;
    if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h want 00000000", dout); end
    n_checks++;
    if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b want 0", sel); end
    rst  = 1'b0;
    addr = 32'h0;
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h2) begin n_fail++; $display("FAIL reset_status got %h want 00000002", rd_data); end
    $display("test_reset: status=%h tx=%b", rd_data, tx);
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [9:0] frame;
    int         bad;
    frame = {1'b1, b, 1'b0};
    bad   = 0;
    clear_rx();
    bus_write(BASE, {24'h0, b});
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_tx got %b want 1", tx); end
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== frame[(i - 1) / CPB]) begin
        n_fail++;
        $display("FAIL single_line cycle %0d got %b want %b", i, tx, frame[(i - 1) / CPB]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL single_post_tx got %b want 1", tx); end
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h2) begin n_fail++; $display("FAIL single_status got %h want 00000002", rd_data); end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      n_fail++;
      $display("FAIL single_rx got %0d bytes want 1 byte %h", rx_q.size(), b);
    end
    $display("test_single: byte=%h status=%h", b, rd_data);
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    clear_rx();
    bus_write(BASE, {24'h0, a});
    bus_write(BASE, {24'h0, b});
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h14) begin n_fail++; $display("FAIL b2b_status_mid got %h want 00000014", rd_data); end
    repeat (2 * FRAME + 5) @(negedge clk);
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h2) begin n_fail++; $display("FAIL b2b_status_end got %h want 00000002", rd_data); end
    n_checks++;
    if (rx_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_rx_count got %0d want 2", rx_q.size());
    end else begin
      n_checks++;
      if (rx_q[0] !== a || rx_q[1] !== b) begin
        n_fail++;
        $display("FAIL b2b_rx_data got %h %h want %h %h", rx_q[0], rx_q[1], a, b);
      end
      n_checks++;
      if (start_q[1] - start_q[0] != FRAME) begin
        n_fail++;
        $display("FAIL b2b_gap got %0d want %0d", start_q[1] - start_q[0], FRAME);
      end
    end
    $display("test_back_to_back: bytes=%h %h", a, b);
  endtask

  task automatic test_overflow();
    logic [7:0]  q_model[$];
    logic [7:0]  exp_line[$];
    logic        model_ovf;
    logic [31:0] exp_status;
    logic [7:0]  p;
    p = 8'($urandom);
    clear_rx();
    q_model.delete();
    model_ovf = 1'b0;
    // The first byte leaves the FIFO at once and keeps the transmitter busy.
    bus_write(BASE, {24'h0, p});
    for (int v = 0; v <= 16; v++) begin
      bus_write(BASE, v);
      if (q_model.size() < DEPTH) q_model.push_back(8'(v));
      else model_ovf = 1'b1;
    end
    exp_status = (32'(q_model.size()) << 4) | (32'(model_ovf) << 3) | 32'h4 |
                 ((q_model.size() == DEPTH) ? 32'h1 : 32'h0);
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== exp_status) begin n_fail++; $display("FAIL ovf_status_full got %h want %h", rd_data, exp_status); end
    bus_write(STAT, 32'h8);
    model_ovf  = 1'b0;
    exp_status = exp_status & ~32'h8;
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== exp_status) begin n_fail++; $display("FAIL ovf_status_clear got %h want %h", rd_data, exp_status); end
    exp_line.delete();
    exp_line.push_back(p);
    foreach (q_model[i]) exp_line.push_back(q_model[i]);
    repeat ((DEPTH + 1) * FRAME + 10) @(negedge clk);
    n_checks++;
    if (rx_q.size() != exp_line.size()) begin
      n_fail++;
      $display("FAIL ovf_rx_count got %0d want %0d", rx_q.size(), exp_line.size());
    end else begin
      for (int i = 0; i < exp_line.size(); i++) begin
        n_checks++;
        if (rx_q[i] !== exp_line[i]) begin
          n_fail++;
          $display("FAIL ovf_rx_byte %0d got %h want %h", i, rx_q[i], exp_line[i]);
        end
      end
    end
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h2) begin n_fail++; $display("FAIL ovf_status_end got %h want 00000002", rd_data); end
    $display("test_overflow: first=%h queued=%0d frames=%0d", p, q_model.size(), rx_q.size());
  endtask

  task automatic test_status_read();
    logic [31:0] a;
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h2 || rd_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL status_read got dout=%h sel=%b want 00000002 1", rd_data, rd_sel);
    end
    bus_read(STAT + 32'd3, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h2 || rd_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL status_alias got dout=%h sel=%b want 00000002 1", rd_data, rd_sel);
    end
    bus_read(BASE, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h0 || rd_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL txdata_read got dout=%h sel=%b want 00000000 1", rd_data, rd_sel);
    end
    for (int i = 0; i < 4; i++) begin
      do a = $urandom; while (a[31:2] == BASE[31:2] || a[31:2] == STAT[31:2]);
      bus_read(a, rd_data, rd_sel);
      n_checks++;
      if (rd_data !== 32'h0 || rd_sel !== 1'b0) begin
        n_fail++;
        $display("FAIL miss_read addr=%h got dout=%h sel=%b want 00000000 0", a, rd_data, rd_sel);
      end
    end
    $display("test_status_read: done");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b[5];
    logic [7:0] nb;
    int         bad;
    foreach (b[i]) b[i] = 8'($urandom);
    clear_rx();
    foreach (b[i]) bus_write(BASE, {24'h0, b[i]});
    // First write at edge N, frame starts after N+1; data bit 3 spans N+18..N+21.
    repeat (15) @(posedge clk);
    #3;
    n_checks++;
    if (tx !== b[0][3]) begin n_fail++; $display("FAIL midframe_bit3 got %b want %b", tx, b[0][3]); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_async_tx got %b want 1", tx); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_rx();
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h2) begin n_fail++; $display("FAIL midframe_status got %h want 00000002", rd_data); end
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL midframe_quiet got %0d low cycles %0d frames want 0 0", bad, rx_q.size());
    end
    nb = 8'($urandom);
    bus_write(BASE, {24'h0, nb});
    repeat (FRAME + 5) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== nb) begin
      n_fail++;
      $display("FAIL midframe_after got %0d frames want 1 frame %h", rx_q.size(), nb);
    end
    $display("test_reset_midframe: first=%h new=%h", b[0], nb);
  endtask

  task automatic test_alias();
    logic [7:0] b;
    b = 8'($urandom);
    clear_rx();
    bus_write(BASE + 32'd2, {24'h0, b});
    n_checks++;
    if (sel !== 1'b1) begin n_fail++; $display("FAIL alias_sel got %b want 1", sel); end
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h10) begin n_fail++; $display("FAIL alias_status got %h want 00000010", rd_data); end
    repeat (FRAME + 5) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      n_fail++;
      $display("FAIL alias_rx got %0d frames want 1 frame %h", rx_q.size(), b);
    end
    clear_rx();
    bus_write(BASE + 32'd8, $urandom);
    n_checks++;
    if (sel !== 1'b0) begin n_fail++; $display("FAIL alias_off_sel got %b want 0", sel); end
    bus_read(STAT, rd_data, rd_sel);
    n_checks++;
    if (rd_data !== 32'h2) begin n_fail++; $display("FAIL alias_off_status got %h want 00000002", rd_data); end
    repeat (FRAME + 10) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL alias_off_rx got %0d frames want 0", rx_q.size()); end
    $display("test_alias: byte=%h", b);
  endtask

  task automatic test_framing();
    n_checks++;
    if (stop_err != 0) begin n_fail++; $display("FAIL stop_bits got %0d bad want 0", stop_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    stop_err = 0;
    test_reset();
    test_single(8'h55);
    test_back_to_back(8'hA3, 8'h0F);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_overflow();
    test_status_read();
    test_reset_midframe();
    test_alias();
    test_framing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the rv32i data bus, in parallel with `dmem` on `daddr`/`ddout`/`dwe*`. The core writes bytes to a TXDATA register. The block queues them in a small FIFO and serializes them 8N1 onto a Pmod pin for host debug output. A STATUS register lets firmware poll FIFO level, busy and overflow. Its read data is registered so it lines up with `dmem`'s synchronous read and can be muxed onto `ddin` using `sel`.

## Interface
- `CLKS_PER_BIT`, 1085: clock cycles per bit (125 MHz / 115200); legal range ≥ 2.
- `BASE_ADDR`, 32'h0001_0000: byte address of TXDATA; STATUS at `BASE_ADDR+4`.
- `FIFO_DEPTH`, 16: TX FIFO entries; power of 2, 2..256.

- `clk`  in  1  system clock (`sysclk`).
- `rst`  in  1  reset; asynchronous, active-high.
- `addr`  in  32  data-bus byte address (`daddr`).
- `din`  in  32  write data (`ddout`).
- `we0`, `we1`, `we2`  in  1 each  data-bus write enables; a write occurs when any is high.
- `dout`  out  32  registered read data for STATUS; 0 otherwise.
- `sel`  out  1  registered: previous-cycle `addr` hit this block (TXDATA or STATUS).
- `tx`  out  1  serial output, idle high.

## Operation
- Address decode:
  - TXDATA hit when `addr[31:2] == BASE_ADDR[31:2]`.
  - STATUS hit when `addr[31:2] == (BASE_ADDR+4)[31:2]`.
  - `addr[1:0]` is ignored.
- Write to TXDATA:
  - Pushes `din[7:0]` if the FIFO is not full.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
- Write to STATUS with `din[3]=1` clears `ovf`. All other STATUS bits ignore writes.
- STATUS layout:
  - bit0 `full`, bit1 `empty`, bit2 `busy` (FSM not IDLE), bit3 `ovf`.
  - bits[12:4] FIFO count, zero-extended.
  - All other bits 0.
- FIFO:
  - Circular buffer with `log2(FIFO_DEPTH)+1`-bit read/write pointers; pointers wrap modulo 2·DEPTH.
  - `full` when the pointer MSBs differ and the low bits are equal; `empty` when the pointers are equal.
  - A push and a pop in the same cycle are both performed and count is unchanged; when full, the push is dropped regardless of a simultaneous pop.
- TX FSM (states IDLE, START, DATA, STOP):
  - A baud counter runs 0..CLKS_PER_BIT-1; each state lasts exactly CLKS_PER_BIT cycles.
  - IDLE: `tx=1`. When the FIFO is non-empty: pop into the shift register, clear the counter, go to START.
  - START: `tx=0`. At counter end go to DATA with bit index 0.
  - DATA: `tx = shift[0]` (LSB first). At counter end shift right and increment the bit index; after bit 7 go to STOP.
  - STOP: `tx=1`. At counter end, if the FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.

## Timing
- Reset values: `tx=1`, `dout=0`, `sel=0`, FSM IDLE, FIFO empty (count 0), `ovf=0`.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and queued bytes are discarded.
- `tx` is driven from a flop; there is no combinational path from inputs to `tx`.
- Write-to-line latency (FIFO empty, FSM IDLE):
  - Write sampled at edge N; byte is in the FIFO after edge N.
  - FSM pops at edge N+1; `tx` falls after edge N+1.
  - The start bit is visible for cycles N+2 .. N+1+CLKS_PER_BIT.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are continuous.
- Read latency:
  - `dout` and `sel` reflect `addr` sampled at edge N and are valid after edge N (one-cycle latency, same as `dmem`).
  - STATUS contents are a snapshot of state before edge N's updates.
- `busy` is 1 from the pop cycle through the final STOP cycle.

## Test plan
- `CLKS_PER_BIT=4`, write 0x55 to TXDATA. Required response:
  - `tx` falls 2 cycles after the write, then reads 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles wide.
  - `tx` returns to 1 after 40 cycles and `busy` drops.
- Write 0xA3 then 0x0F on consecutive cycles. Required response:
  - Two frames with no idle cycles between them.
  - STATUS count reads 1 during the first frame and `empty=1` after the second frame's stop bit.
- With the FSM held busy, write 17 bytes 0x00..0x10. Required response:
  - 16 bytes are queued and `full=1`; 0x10 is dropped and `ovf=1`.
  - After writing STATUS with `din=8`, `ovf=0`.
  - The serialized sequence is the first byte popped followed by the remaining queued bytes in order, excluding 0x10.
- STATUS read of an empty, idle block. Required response:
  - `dout = 32'h0000_0002` and `sel=1` one cycle after `addr` is presented.
  - A non-matching `addr` gives `dout=0`, `sel=0`.
- Assert `rst` during DATA bit 3 of a frame with 5 bytes queued. Required response:
  - `tx=1` immediately, count 0, `ovf=0`.
  - No further frames after reset release until a new write.
- Address alias check. Required response:
  - A write to `BASE_ADDR+2` pushes a byte.
  - A write to `BASE_ADDR+8` is ignored (count unchanged, `sel=0`).
